// File: rtl/pll_seq_pkg.sv
// Shared state encoding and default timing constants for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StHold,
    StWaitLock,
    StStable,
    StRun,
    StFault
  } state_e;

  localparam int unsigned DefRstHoldCycles = 1000;
  localparam int unsigned DefLockTimeout   = 50000;
  localparam int unsigned DefStableCycles  = 256;
  localparam int unsigned DefMaxRetries    = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared by async reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for a stable lock with retries,
// then releases the downstream system reset; recovers from lock loss and faults.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = DefRstHoldCycles,
  parameter int unsigned LOCK_TIMEOUT    = DefLockTimeout,
  parameter int unsigned STABLE_CYCLES   = DefStableCycles,
  parameter int unsigned MAX_RETRIES     = DefMaxRetries
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned CntW = $clog2(max3(RST_HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

  localparam logic [CntW-1:0] HoldLast    = CntW'(RST_HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [3:0]      MaxRetries  = 4'(MAX_RETRIES);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d;
  logic [7:0]      loss_q, loss_d;
  logic            lock_s;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (lock_s)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHold;
      cnt_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    unique case (state_q)
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitLock: begin
        if (lock_s) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d   = '0;
          retry_d = retry_q + 4'd1;
          state_d = (retry_d == MaxRetries) ? StFault : StHold;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStable: begin
        // Any dropout restarts the lock wait without consuming a retry.
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d = StHold;
          cnt_d   = '0;
          if (loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
          end
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StHold;
        cnt_d   = '0;
      end
    endcase

    // Loss accounting above still applies when a soft reset coincides with it.
    if (soft_reset) begin
      state_d = StHold;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  assign pll_rst       = (state_q == StHold) || (state_q == StFault);
  assign sys_rst_n     = (state_q == StRun);
  assign ready         = (state_q == StRun);
  assign fault         = (state_q == StFault);
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios plus a randomized run
// against a countdown-based behavioural model.
module tb_pll_reset_sequencer;

  localparam int Hold = 4;
  localparam int Tmo  = 20;
  localparam int Stab = 8;
  localparam int MaxR = 2;

  localparam int PhHold   = 0;
  localparam int PhWait   = 1;
  localparam int PhStable = 2;
  localparam int PhRun    = 3;
  localparam int PhFault  = 4;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       locked = 1'b0;
  logic       soft_reset = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int n_checks = 0;
  int n_fail = 0;

  int   m_phase, m_left, m_retry, m_loss;
  logic m_s1, m_s2;

  always #10 refclk = ~refclk;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES (Hold),
    .LOCK_TIMEOUT    (Tmo),
    .STABLE_CYCLES   (Stab),
    .MAX_RETRIES     (MaxR)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .locked        (locked),
    .soft_reset    (soft_reset),
    .pll_rst       (pll_rst),
    .sys_rst_n     (sys_rst_n),
    .ready         (ready),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  function automatic logic sel(input int which);
    case (which)
      0:       return pll_rst;
      1:       return sys_rst_n;
      2:       return ready;
      default: return fault;
    endcase
  endfunction

  // Returns the number of falling edges until the chosen output equals val, or -1.
  task automatic wait_until(input int which, input logic val, input int limit, output int k);
    k = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge refclk);
      if (sel(which) === val) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge refclk);
    rst_n = 1'b0;
    locked = 1'b0;
    soft_reset = 1'b0;
    repeat (2) @(negedge refclk);
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    m_phase = PhHold;
    m_left  = Hold;
    m_retry = 0;
    m_loss  = 0;
    m_s1    = 1'b0;
    m_s2    = 1'b0;
  endtask

  task automatic model_step(input logic lk, input logic sr);
    logic ls;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = lk;
    if (m_phase == PhRun && !ls && m_loss < 255) m_loss++;
    if (sr) begin
      m_phase = PhHold;
      m_left  = Hold;
      m_retry = 0;
    end else begin
      case (m_phase)
        PhHold: begin
          m_left--;
          if (m_left == 0) begin m_phase = PhWait; m_left = Tmo; end
        end
        PhWait: begin
          if (ls) begin
            m_phase = PhStable;
            m_left  = Stab;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_retry++;
              if (m_retry == MaxR) m_phase = PhFault;
              else begin m_phase = PhHold; m_left = Hold; end
            end
          end
        end
        PhStable: begin
          if (!ls) begin
            m_phase = PhWait;
            m_left  = Tmo;
          end else begin
            m_left--;
            if (m_left == 0) begin m_phase = PhRun; m_retry = 0; end
          end
        end
        PhRun: if (!ls) begin m_phase = PhHold; m_left = Hold; end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    @(negedge refclk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset.pll_rst got=%b exp=1", pll_rst); end
    n_checks++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset.sys_rst_n got=%b exp=0", sys_rst_n); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset.ready got=%b exp=0", ready); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset.fault got=%b exp=0", fault); end
    n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL reset.retry_cnt got=%0d exp=0", retry_cnt); end
    n_checks++; if (lock_loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset.lock_loss_cnt got=%0d exp=0", lock_loss_cnt); end
  endtask

  task automatic test_bringup();
    int k;
    @(negedge refclk);
    rst_n = 1'b1;
    wait_until(0, 1'b0, 20, k);
    n_checks++; if (k != Hold) begin n_fail++; $display("FAIL bringup.hold_len got=%0d exp=%0d", k, Hold); end
    repeat (5) @(negedge refclk);
    locked = 1'b1;
    wait_until(1, 1'b1, 40, k);
    n_checks++; if (k != 11) begin n_fail++; $display("FAIL bringup.release_latency got=%0d exp=11", k); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL bringup.ready got=%b exp=1", ready); end
    n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL bringup.retry_cnt got=%0d exp=0", retry_cnt); end
    n_checks++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL bringup.pll_rst got=%b exp=0", pll_rst); end
  endtask

  task automatic test_lock_loss();
    int k;
    locked = 1'b0;
    wait_until(1, 1'b0, 10, k);
    n_checks++; if (k < 1 || k > 3) begin n_fail++; $display("FAIL lockloss.sys_rst_latency got=%0d exp<=3", k); end
    n_checks++; if (lock_loss_cnt !== 8'd1) begin n_fail++; $display("FAIL lockloss.count got=%0d exp=1", lock_loss_cnt); end
    n_checks++; if (ready !== 1'b0 || pll_rst !== 1'b1) begin n_fail++; $display("FAIL lockloss.hold got ready=%b pll_rst=%b exp 0 1", ready, pll_rst); end
    wait_until(0, 1'b0, 20, k);
    n_checks++; if (k != Hold) begin n_fail++; $display("FAIL lockloss.pll_rst_len got=%0d exp=%0d", k, Hold); end
    locked = 1'b1;
    wait_until(2, 1'b1, 40, k);
    n_checks++; if (k != 11) begin n_fail++; $display("FAIL lockloss.relock_latency got=%0d exp=11", k); end
  endtask

  task automatic test_soft_in_run();
    locked = 1'b0;
    repeat (2) @(negedge refclk);
    soft_reset = 1'b1;
    @(negedge refclk);
    soft_reset = 1'b0;
    n_checks++; if (lock_loss_cnt !== 8'd2) begin n_fail++; $display("FAIL softrun.count got=%0d exp=2", lock_loss_cnt); end
    n_checks++; if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL softrun.hold got pll_rst=%b sys_rst_n=%b exp 1 0", pll_rst, sys_rst_n); end
    locked = 1'b1;
    repeat (5) @(negedge refclk);
    n_checks++; if (lock_loss_cnt !== 8'd2) begin n_fail++; $display("FAIL softrun.no_double got=%0d exp=2", lock_loss_cnt); end
  endtask

  task automatic test_lock_timeout();
    int lows[4];
    int nl, cur, bad, k;
    bit seen_fault;
    nl = 0; cur = 0; bad = 0; seen_fault = 1'b0;
    for (int i = 0; i < 4; i++) lows[i] = 0;
    apply_reset();
    for (int i = 0; i < 200 && !seen_fault; i++) begin
      @(negedge refclk);
      if (fault === 1'b1) seen_fault = 1'b1;
      else if (pll_rst === 1'b0) cur++;
      else if (cur > 0) begin
        if (nl < 4) lows[nl] = cur;
        nl++;
        cur = 0;
      end
    end
    if (cur > 0) begin
      if (nl < 4) lows[nl] = cur;
      nl++;
    end
    n_checks++; if (!seen_fault) begin n_fail++; $display("FAIL timeout.fault_reached got=0 exp=1"); end
    n_checks++; if (nl != MaxR) begin n_fail++; $display("FAIL timeout.attempts got=%0d exp=%0d", nl, MaxR); end
    n_checks++; if (lows[0] != Tmo || lows[1] != Tmo) begin n_fail++; $display("FAIL timeout.window got=%0d,%0d exp=%0d", lows[0], lows[1], Tmo); end
    n_checks++; if (retry_cnt !== 4'd2) begin n_fail++; $display("FAIL timeout.retry_cnt got=%0d exp=2", retry_cnt); end
    n_checks++; if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL timeout.outputs got pll_rst=%b sys_rst_n=%b exp 1 0", pll_rst, sys_rst_n); end
    repeat (100) begin
      @(negedge refclk);
      if (fault !== 1'b1 || pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || retry_cnt !== 4'd2) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL timeout.fault_stable got=%0d bad cycles exp=0", bad); end
    soft_reset = 1'b1;
    @(negedge refclk);
    soft_reset = 1'b0;
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL softfault.fault got=%b exp=0", fault); end
    n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL softfault.retry_cnt got=%0d exp=0", retry_cnt); end
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL softfault.pll_rst got=%b exp=1", pll_rst); end
    wait_until(0, 1'b0, 20, k);
    n_checks++; if (k != Hold) begin n_fail++; $display("FAIL softfault.hold_len got=%0d exp=%0d", k, Hold); end
  endtask

  task automatic test_lock_glitch();
    int k, first, pll_hi;
    first = -1; pll_hi = 0;
    apply_reset();
    wait_until(0, 1'b0, 20, k);
    locked = 1'b1;
    repeat (8) @(negedge refclk);
    locked = 1'b0;
    @(negedge refclk);
    locked = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge refclk);
      if (pll_rst === 1'b1) pll_hi++;
      if (sys_rst_n === 1'b1 && first < 0) first = i;
    end
    n_checks++; if (first != 11) begin n_fail++; $display("FAIL glitch.recovery_latency got=%0d exp=11", first); end
    n_checks++; if (pll_hi != 0) begin n_fail++; $display("FAIL glitch.no_hold got=%0d exp=0", pll_hi); end
    n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL glitch.retry_cnt got=%0d exp=0", retry_cnt); end
  endtask

  task automatic test_reset_mid_stable();
    int k, bad;
    bad = 0;
    apply_reset();
    wait_until(0, 1'b0, 20, k);
    locked = 1'b1;
    repeat (5) @(negedge refclk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || ready !== 1'b0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL midreset.outputs got pll_rst=%b sys_rst_n=%b ready=%b fault=%b exp 1 0 0 0", pll_rst, sys_rst_n, ready, fault);
    end
    repeat (3) begin
      @(negedge refclk);
      if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || ready !== 1'b0 || retry_cnt !== 4'd0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midreset.held got=%0d bad cycles exp=0", bad); end
    rst_n = 1'b1;
    wait_until(0, 1'b0, 20, k);
    n_checks++; if (k != Hold) begin n_fail++; $display("FAIL midreset.hold_len got=%0d exp=%0d", k, Hold); end
    wait_until(2, 1'b1, 40, k);
    n_checks++; if (k != 9) begin n_fail++; $display("FAIL midreset.run_latency got=%0d exp=9", k); end
  endtask

  task automatic test_random();
    int   run_left;
    logic lvl, e_pll, e_run, e_fault;
    run_left = 0;
    lvl = 1'b0;
    apply_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if (run_left == 0) begin
        lvl = ($urandom_range(9) < 7);
        run_left = $urandom_range(40, 1);
      end
      run_left--;
      locked = lvl;
      soft_reset = ($urandom_range(63) == 0);
      @(posedge refclk);
      model_step(locked, soft_reset);
      @(negedge refclk);
      e_pll   = (m_phase == PhHold) || (m_phase == PhFault);
      e_run   = (m_phase == PhRun);
      e_fault = (m_phase == PhFault);
      n_checks++;
      if (pll_rst !== e_pll || sys_rst_n !== e_run || ready !== e_run || fault !== e_fault ||
          retry_cnt !== 4'(m_retry) || lock_loss_cnt !== 8'(m_loss)) begin
        n_fail++;
        $display("FAIL random cycle %0d: got pll_rst=%b sys_rst_n=%b ready=%b fault=%b retry=%0d loss=%0d exp %b %b %b %b %0d %0d",
                 c, pll_rst, sys_rst_n, ready, fault, retry_cnt, lock_loss_cnt,
                 e_pll, e_run, e_run, e_fault, m_retry, m_loss);
      end
    end
    soft_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_loss();
    test_soft_in_run();
    test_lock_timeout();
    test_lock_glitch();
    test_reset_mid_stable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter RST_HOLD_CYCLES, default 1000, refclk cycles pll_rst is held high per attempt (20 us at 50 MHz); SHALL be >= 2.
REQ-002 Parameter LOCK_TIMEOUT, default 50000, refclk cycles allowed in WAIT_LOCK per attempt (1 ms); SHALL be >= 2.
REQ-003 Parameter STABLE_CYCLES, default 256, consecutive synchronized-lock cycles required before release; SHALL be >= 2.
REQ-004 Parameter MAX_RETRIES, default 3, failed lock attempts before FAULT; SHALL be 1..15.
REQ-005 refclk  in  1  single clock, 50 MHz PLL reference; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 locked  in  1  PLL lock flag, asynchronous to refclk.
REQ-008 soft_reset  in  1  one-cycle request to restart the sequence.
REQ-009 pll_rst  out  1  active-high reset to the PLL rst input.
REQ-010 sys_rst_n  out  1  active-low reset request for logic clocked by the PLL outputs.
REQ-011 ready  out  1  high only in RUN.
REQ-012 fault  out  1  high only in FAULT.
REQ-013 retry_cnt  out  4  failed attempts in the current sequence.
REQ-014 lock_loss_cnt  out  8  saturating count of lock losses seen in RUN.

Function
REQ-015 locked SHALL pass through a 2-FF synchronizer; lock_s denotes its output; only lock_s is used.
REQ-016 FSM states: HOLD, WAIT_LOCK, STABLE, RUN, FAULT; all outputs registered or decoded from state registers, with no combinational path from inputs.
REQ-017 HOLD: pll_rst=1; counter runs 0..RST_HOLD_CYCLES-1, then state goes to WAIT_LOCK and the counter clears.
REQ-018 WAIT_LOCK: pll_rst=0; lock_s=1 -> STABLE with counter cleared; counter reaching LOCK_TIMEOUT-1 with lock_s=0 -> retry_cnt+1, then FAULT if the new value equals MAX_RETRIES, else HOLD.
REQ-019 STABLE: lock_s=0 -> WAIT_LOCK with timeout counter cleared and retry_cnt unchanged; STABLE_CYCLES consecutive cycles of lock_s=1 -> RUN.
REQ-020 Entering RUN SHALL set sys_rst_n=1 and ready=1 in the same cycle and clear retry_cnt.
REQ-021 RUN: lock_s=0 -> HOLD; sys_rst_n=0 and ready=0 on the cycle HOLD is entered; lock_loss_cnt+1, saturating at 255.
REQ-022 FAULT: pll_rst=1, fault=1, sys_rst_n=0; exit only via soft_reset.
REQ-023 soft_reset has highest priority in every state: next state HOLD, counter cleared, retry_cnt cleared; in HOLD it restarts the hold count.
REQ-024 soft_reset coincident with RUN lock loss: go to HOLD and count the loss exactly once.
REQ-025 sys_rst_n SHALL be 0 in every state except RUN.
REQ-026 Counter width: $clog2 of the largest of RST_HOLD_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES, plus 1; it never wraps.

Reset
REQ-027 rst_n low SHALL immediately force: state=HOLD, counter=0, pll_rst=1, sys_rst_n=0, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, synchronizer flops=0.
REQ-028 Assertion of rst_n in any state, including mid-STABLE or in RUN, SHALL abort the sequence with no partial output; sequencing restarts from HOLD on the first refclk edge after rst_n deasserts.

Structure
REQ-029 Package pll_seq_pkg holds the state enum and the default parameter constants.
REQ-030 Sub-module sync_2ff (1-bit, asynchronous active-low clear) implements REQ-015; everything else stays in pll_reset_sequencer.

Verification (RST_HOLD_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-031 Normal bring-up: locked rises 5 cycles after pll_rst falls -> sys_rst_n=1 and ready=1 exactly 11 cycles after the locked edge (2 sync + 1 + 8); retry_cnt=0.
REQ-032 locked held 0: pll_rst deasserts twice for 20 cycles each -> retry_cnt=2, fault=1, pll_rst=1; bench then checks fault=1 stays stable for 100 cycles.
REQ-033 Lock glitch: locked high for 5 cycles during STABLE, then low 1 cycle, then high -> return to WAIT_LOCK; RUN reached 8 full stable cycles after recovery; retry_cnt unchanged.
REQ-034 Lock loss in RUN: locked drops -> sys_rst_n=0 within 3 cycles, lock_loss_cnt=1, pll_rst=1 for 4 cycles; re-lock -> RUN again.
REQ-035 soft_reset in FAULT -> HOLD, fault=0, retry_cnt=0; soft_reset in the same cycle as a RUN lock loss -> lock_loss_cnt increments by exactly 1.
REQ-036 rst_n pulsed low mid-STABLE -> all outputs at REQ-027 values during reset; full sequence restarts from HOLD.
